id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage for the ARM-subset pipeline. It combines the following into one block with a registered ID/EX boundary:
- control decode
- condition-code check
- hazard bubble insertion
- an internal register file with writeback port
- stall/flush handling

It sits between the IF/ID register and EXE, and exports source-register info combinationally to the hazard unit.

Parameters:
DATA_W, 32, datapath and register width
NUM_REGS, 15, architectural registers R0..R(NUM_REGS-1); must be <= 2**ADDR_W
ADDR_W, 4, register index width
BYPASS, 1, 1 = a same-cycle writeback is visible on read ports (write-first)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset
instruction  in  32  instruction from IF/ID
pc_in  in  32  PC from IF/ID
valid_in  in  1  IF/ID holds a real instruction
z,c,n,v  in  1 each  status-register flags
hazard  in  1  insert bubble (from hazard unit)
stall  in  1  hold ID/EX register
flush  in  1  clear ID/EX register (taken branch)
wb_wb_en  in  1  writeback enable
wb_dest  in  ADDR_W  writeback register index
wb_value  in  DATA_W  writeback data
src1  out  ADDR_W  combinational: instruction[19:16]
src2  out  ADDR_W  combinational: STR ? instruction[15:12] : instruction[3:0]
two_src  out  1  combinational: (~I & mode==00) | MEM_W
wb_en_o, mem_r_o, mem_w_o, b_o, s_o  out  1 each  registered controls
exe_cmd_o  out  4  registered ALU command
pc_o  out  32  registered PC
val_rn_o, val_rm_o  out  DATA_W  registered operands
dest_o  out  ADDR_W  registered Rd
imm_o  out  1  registered I bit
shift_operand_o  out  12  registered instruction[11:0]
signed_imm24_o  out  24  registered instruction[23:0]
src1_o, src2_o  out  ADDR_W  registered source indices, for forwarding
valid_o  out  1  ID/EX holds a real instruction

Behaviour:
- Reset (rst=0 at a rising edge):
  - every registered output is 0;
  - register file entry i is loaded with value i, zero-extended to DATA_W.
- Instruction fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12].
- Control decode, mode 00:
  - MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000: all with WB_EN=1.
  - CMP 1010→0100 and TST 1000→0110: WB_EN=0.
  - Any other opcode: all controls 0.
  - S output = S bit.
- Control decode, mode 01:
  - S=1 is LDR: exe_cmd 0010, MEM_R=1, WB_EN=1.
  - S=0 is STR: exe_cmd 0010, MEM_W=1.
  - s_o=0 for both.
- Control decode, mode 10: B=1, all other controls 0.
- Control decode, mode 11: all controls 0.
- Condition check, cond → pass:
  - EQ z, NE ~z, CS c, CC ~c, MI n, PL ~n, VS v, VC ~v
  - HI c&~z, LS ~c|z, GE n==v, LT n!=v
  - GT ~z&(n==v), LE z|(n!=v)
  - AL 1, 1111 0
- Bubble: the 9 control bits (wb_en, mem_r, mem_w, exe_cmd, b, s) are forced to 0 when any of these holds: hazard=1, condition fails, or valid_in=0. The data fields still propagate.
- Register file:
  - Write at a rising edge when wb_wb_en=1 and wb_dest<NUM_REGS.
  - Writes to indices >= NUM_REGS are ignored; reads of those indices return 0.
  - Reads are combinational; val_rn reads Rn, val_rm reads src2.
  - BYPASS=1: a read whose index equals wb_dest while wb_wb_en=1 returns wb_value in the same cycle.
  - BYPASS=0: the read returns the old value.
- ID/EX register update, by priority:
  1. rst=0: clear.
  2. flush=1: clear, valid_o=0. Flush wins over stall.
  3. stall=1: hold all outputs.
  4. Otherwise: load the decoded values; valid_o = valid_in & ~hazard.
- Latency: one cycle from instruction to registered outputs.
- The register-file write is not blocked by stall or flush.
- Reset mid-operation clears both the pipeline register and the register file in the same edge.

Decomposition:
- Package id_pkg holds:
  - mode, opcode, exe_cmd and cond encodings as localparams;
  - the control-bundle field offsets.
- One natural sub-module: reg_file (parameters DATA_W, NUM_REGS, ADDR_W, BYPASS; synchronous write, async read, reset to index).
- Control decode and condition check are combinational functions inside id_stage_pipe.

Test Plan:
- Reset then instruction 0xE0821003 (ADD R1,R2,R3, AL), valid_in=1:
  - next edge: exe_cmd_o=0010, wb_en_o=1, val_rn_o=2, val_rm_o=3, dest_o=1, valid_o=1;
  - two_src=1 before the edge.
- With z=0, instruction 0x03A01005 (MOVEQ R1,#5):
  - all controls 0, imm_o=1, shift_operand_o=0x005, valid_o=1.
- wb_wb_en=1, wb_dest=2, wb_value=0xDEAD in the same cycle as ADD R1,R2,R3:
  - BYPASS=1 gives val_rn_o=0xDEAD;
  - BYPASS=0 gives 2;
  - the following read of R2 returns 0xDEAD in both cases.
- Load STR 0xE5821000, then raise stall for 2 cycles while the instruction changes:
  - outputs hold mem_w_o=1, src2_o=1 throughout.
- stall=1 and flush=1 together:
  - next edge all outputs 0, valid_o=0.
- hazard=1 with LDR 0xE5921000:
  - registered controls 0, valid_o=0, dest_o=1.
- Then NUM_REGS=8 and a write to R9:
  - the write is ignored and a read of R9 returns 0.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared encodings for the ID stage: instruction modes, opcodes, ALU commands,
// condition codes and the bit layout of the 9-bit control bundle.
package id_pkg;

    // Instruction mode field [27:26]
    localparam logic [1:0] MODE_ALU  = 2'b00;
    localparam logic [1:0] MODE_MEM  = 2'b01;
    localparam logic [1:0] MODE_BR   = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    // Data-processing opcode field [24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU command sent to EXE
    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Condition field [31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Control bundle layout: {wb_en, mem_r, mem_w, exe_cmd[3:0], b, s}
    localparam int CTRL_W       = 9;
    localparam int CTRL_S       = 0;
    localparam int CTRL_B       = 1;
    localparam int CTRL_CMD_LSB = 2;
    localparam int CTRL_CMD_W   = 4;
    localparam int CTRL_MEM_W   = 6;
    localparam int CTRL_MEM_R   = 7;
    localparam int CTRL_WB_EN   = 8;

endpackage

// File: rtl/id_stage_pipe_reg_file.sv
// Architectural register file: one synchronous write port, two asynchronous
// read ports, every entry reset to its own index. Indices at or beyond
// NUM_REGS are not backed by storage: writes to them vanish, reads give 0.
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    input  logic [ADDR_W-1:0] rd2_addr_i,
    output logic [DATA_W-1:0] rd2_data_o
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;
    logic              rd1_ok, rd2_ok;
    logic              rd1_hit, rd2_hit;

    assign wr_ok  = wr_en_i && ({1'b0, wr_addr_i} < NUM_REGS_L);
    assign rd1_ok = {1'b0, rd1_addr_i} < NUM_REGS_L;
    assign rd2_ok = {1'b0, rd2_addr_i} < NUM_REGS_L;

    // A same-cycle writeback is forwarded to the readers only in write-first mode
    assign rd1_hit = (BYPASS != 0) && wr_ok && (wr_addr_i == rd1_addr_i);
    assign rd2_hit = (BYPASS != 0) && wr_ok && (wr_addr_i == rd2_addr_i);

    assign rd1_data_o = !rd1_ok ? '0 : (rd1_hit ? wr_data_i : mem_q[rd1_addr_i]);
    assign rd2_data_o = !rd2_ok ? '0 : (rd2_hit ? wr_data_i : mem_q[rd2_addr_i]);

    // Storage: reset loads each entry with its index, otherwise accept one write
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                mem_q[i] <= (i < NUM_REGS) ? DATA_W'(i) : '0;
            end else if (wr_ok && (wr_addr_i == ADDR_W'(i))) begin
                mem_q[i] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: control decode, condition check, bubble insertion,
// register-file read and the ID/EX pipeline register with stall/flush.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_in,
    input  logic              valid_in,
    input  logic              z,
    input  logic              c,
    input  logic              n,
    input  logic              v,
    input  logic              hazard,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic [ADDR_W-1:0] src1,
    output logic [ADDR_W-1:0] src2,
    output logic              two_src,
    output logic              wb_en_o,
    output logic              mem_r_o,
    output logic              mem_w_o,
    output logic              b_o,
    output logic              s_o,
    output logic [3:0]        exe_cmd_o,
    output logic [31:0]       pc_o,
    output logic [DATA_W-1:0] val_rn_o,
    output logic [DATA_W-1:0] val_rm_o,
    output logic [ADDR_W-1:0] dest_o,
    output logic              imm_o,
    output logic [11:0]       shift_operand_o,
    output logic [23:0]       signed_imm24_o,
    output logic [ADDR_W-1:0] src1_o,
    output logic [ADDR_W-1:0] src2_o,
    output logic              valid_o
);

    // Map mode/opcode/S to the control bundle; unknown opcodes decode to all-zero
    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [1:0] mode,
                                                      input logic [3:0] op,
                                                      input logic       s);
        logic [CTRL_W-1:0] ctrl;
        logic [3:0]        cmd;
        logic              wb;
        ctrl = '0;
        cmd  = CMD_NOP;
        wb   = 1'b0;
        case (mode)
            MODE_ALU: begin
                wb = 1'b1;
                case (op)
                    OP_MOV:  cmd = CMD_MOV;
                    OP_MVN:  cmd = CMD_MVN;
                    OP_ADD:  cmd = CMD_ADD;
                    OP_ADC:  cmd = CMD_ADC;
                    OP_SUB:  cmd = CMD_SUB;
                    OP_SBC:  cmd = CMD_SBC;
                    OP_AND:  cmd = CMD_AND;
                    OP_ORR:  cmd = CMD_ORR;
                    OP_EOR:  cmd = CMD_EOR;
                    OP_CMP:  begin cmd = CMD_SUB; wb = 1'b0; end
                    OP_TST:  begin cmd = CMD_AND; wb = 1'b0; end
                    default: begin cmd = CMD_NOP; wb = 1'b0; end
                endcase
                ctrl[CTRL_CMD_LSB +: CTRL_CMD_W] = cmd;
                ctrl[CTRL_WB_EN] = wb;
                // The S bit only travels with a recognised data-processing opcode
                ctrl[CTRL_S] = (cmd != CMD_NOP) ? s : 1'b0;
            end
            MODE_MEM: begin
                ctrl[CTRL_CMD_LSB +: CTRL_CMD_W] = CMD_ADD;
                if (s) begin
                    ctrl[CTRL_MEM_R] = 1'b1;
                    ctrl[CTRL_WB_EN] = 1'b1;
                end else begin
                    ctrl[CTRL_MEM_W] = 1'b1;
                end
            end
            MODE_BR:   ctrl[CTRL_B] = 1'b1;
            MODE_NONE: ctrl = '0;
            default:   ctrl = '0;
        endcase
        return ctrl;
    endfunction

    // Evaluate the condition field against the current status flags
    function automatic logic cond_pass(input logic [3:0] cond,
                                       input logic zf, input logic cf,
                                       input logic nf, input logic vf);
        logic pass;
        case (cond)
            COND_EQ: pass = zf;
            COND_NE: pass = ~zf;
            COND_CS: pass = cf;
            COND_CC: pass = ~cf;
            COND_MI: pass = nf;
            COND_PL: pass = ~nf;
            COND_VS: pass = vf;
            COND_VC: pass = ~vf;
            COND_HI: pass = cf & ~zf;
            COND_LS: pass = ~cf | zf;
            COND_GE: pass = (nf == vf);
            COND_LT: pass = (nf != vf);
            COND_GT: pass = ~zf & (nf == vf);
            COND_LE: pass = zf | (nf != vf);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    logic [1:0]        mode;
    logic [3:0]        opcode;
    logic [3:0]        cond;
    logic              imm_bit;
    logic              s_bit;
    logic              is_str;
    logic              cond_ok;
    logic              bubble;
    logic [CTRL_W-1:0] ctrl_raw;
    logic [CTRL_W-1:0] ctrl_id;
    logic [DATA_W-1:0] rn_val;
    logic [DATA_W-1:0] rm_val;

    assign cond    = instruction[31:28];
    assign mode    = instruction[27:26];
    assign imm_bit = instruction[25];
    assign opcode  = instruction[24:21];
    assign s_bit   = instruction[20];

    assign is_str   = (mode == MODE_MEM) && !s_bit;
    assign ctrl_raw = decode_ctrl(mode, opcode, s_bit);
    assign cond_ok  = cond_pass(cond, z, c, n, v);
    assign bubble   = hazard | ~cond_ok | ~valid_in;
    assign ctrl_id  = bubble ? '0 : ctrl_raw;

    // STR carries its store data register in the Rd slot
    assign src1    = ADDR_W'(instruction[19:16]);
    assign src2    = is_str ? ADDR_W'(instruction[15:12]) : ADDR_W'(instruction[3:0]);
    assign two_src = (~imm_bit & (mode == MODE_ALU)) | is_str;

    reg_file #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wb_wb_en),
        .wr_addr_i (wb_dest),
        .wr_data_i (wb_value),
        .rd1_addr_i(src1),
        .rd1_data_o(rn_val),
        .rd2_addr_i(src2),
        .rd2_data_o(rm_val)
    );

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] val_rn_q, val_rn_d;
    logic [DATA_W-1:0] val_rm_q, val_rm_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              imm_q, imm_d;
    logic [11:0]       shift_q, shift_d;
    logic [23:0]       simm_q, simm_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] src2_q, src2_d;
    logic              valid_q, valid_d;

    // ID/EX next state: flush clears, stall holds, otherwise load the decode
    always_comb begin
        ctrl_d   = ctrl_q;
        pc_d     = pc_q;
        val_rn_d = val_rn_q;
        val_rm_d = val_rm_q;
        dest_d   = dest_q;
        imm_d    = imm_q;
        shift_d  = shift_q;
        simm_d   = simm_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        valid_d  = valid_q;
        if (flush) begin
            ctrl_d   = '0;
            pc_d     = '0;
            val_rn_d = '0;
            val_rm_d = '0;
            dest_d   = '0;
            imm_d    = 1'b0;
            shift_d  = '0;
            simm_d   = '0;
            src1_d   = '0;
            src2_d   = '0;
            valid_d  = 1'b0;
        end else if (!stall) begin
            ctrl_d   = ctrl_id;
            pc_d     = pc_in;
            val_rn_d = rn_val;
            val_rm_d = rm_val;
            dest_d   = ADDR_W'(instruction[15:12]);
            imm_d    = imm_bit;
            shift_d  = instruction[11:0];
            simm_d   = instruction[23:0];
            src1_d   = src1;
            src2_d   = src2;
            valid_d  = valid_in & ~hazard;
        end
    end

    // ID/EX register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q   <= '0;
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
            dest_q   <= '0;
            imm_q    <= 1'b0;
            shift_q  <= '0;
            simm_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            val_rn_q <= val_rn_d;
            val_rm_q <= val_rm_d;
            dest_q   <= dest_d;
            imm_q    <= imm_d;
            shift_q  <= shift_d;
            simm_q   <= simm_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            valid_q  <= valid_d;
        end
    end

    assign wb_en_o         = ctrl_q[CTRL_WB_EN];
    assign mem_r_o         = ctrl_q[CTRL_MEM_R];
    assign mem_w_o         = ctrl_q[CTRL_MEM_W];
    assign exe_cmd_o       = ctrl_q[CTRL_CMD_LSB +: CTRL_CMD_W];
    assign b_o             = ctrl_q[CTRL_B];
    assign s_o             = ctrl_q[CTRL_S];
    assign pc_o            = pc_q;
    assign val_rn_o        = val_rn_q;
    assign val_rm_o        = val_rm_q;
    assign dest_o          = dest_q;
    assign imm_o           = imm_q;
    assign shift_operand_o = shift_q;
    assign signed_imm24_o  = simm_q;
    assign src1_o          = src1_q;
    assign src2_o          = src2_q;
    assign valid_o         = valid_q;

endmodule
